// File: rtl/morse_receptor.sv
// -----------------------------------------------------------------------------
// morse_receptor
//   Morse receiver. Samples a keyed on/off line, times marks and spaces in
//   ticks of an external strobe, classifies each mark as dot or dash and
//   assembles up to five elements per letter. The letter is emitted as a
//   5-bit code (element k at bit k, 1 = dash) plus its length, which is the
//   same code format the Morse transmitter's code table uses.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   tick      in   1  one-cycle timing strobe
//   linea     in   1  keyed line, asynchronous, 1 = mark
//   codigo    out  5  last received code, held between valido pulses
//   longitud  out  3  number of elements in codigo (1..5)
//   valido    out  1  one-cycle pulse when codigo/longitud update
//   error     out  1  one-cycle pulse on entering the error state
//   ocupado   out  1  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module morse_receptor #(
    parameter int CNT_W      = 8,
    parameter int MARK_MIN   = 1,
    parameter int DOT_MAX    = 2,
    parameter int MARK_MAX   = 6,
    parameter int GAP_LETTER = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       linea,
    output logic [4:0] codigo,
    output logic [2:0] longitud,
    output logic       valido,
    output logic       error,
    output logic       ocupado
);

    localparam logic [CNT_W-1:0] L_MARK_MIN = CNT_W'(MARK_MIN);
    localparam logic [CNT_W-1:0] L_DOT_MAX  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] L_MARK_MAX = CNT_W'(MARK_MAX);
    localparam logic [CNT_W-1:0] L_GAP_M1   = CNT_W'(GAP_LETTER - 1);
    localparam logic [CNT_W-1:0] L_CNT_SAT  = '1;
    localparam logic [2:0]       L_MAX_ELEM = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_ERROR
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;     // linea_s
    logic             r_prev;      // linea_s one cycle earlier
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_shift;
    logic [2:0]       r_n;
    logic [4:0]       r_codigo;
    logic [2:0]       r_longitud;
    logic             r_valido;
    logic             r_error;
    logic             r_ocupado;

    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_gap_hit;
    logic w_dash;

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;
    assign w_edge = w_rise | w_fall;

    // The low-line count is about to reach GAP_LETTER on this tick. An edge in
    // the same cycle clears the counter instead, so it suppresses the hit.
    assign w_gap_hit = tick & ~w_edge & ~r_sync2 & (r_cnt == L_GAP_M1);

    assign w_dash = (r_cnt > L_DOT_MAX);

    // Two-flop synchroniser plus one history flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking would collapse
    // the chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= linea;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Duration counter: restarts on every line edge, held at 0 while idle,
    // saturates instead of wrapping so a stuck line stays classified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_edge || r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (tick && r_cnt != L_CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_n        <= '0;
            r_codigo   <= '0;
            r_longitud <= '0;
            r_valido   <= 1'b0;
            r_error    <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state   <= S_MARK;
                        r_ocupado <= 1'b1;
                    end
                end

                S_MARK: begin
                    if (w_fall) begin
                        if (r_cnt < L_MARK_MIN) begin
                            // Glitch: drop the mark, resume whatever came before.
                            if (r_n != 3'd0) begin
                                r_state <= S_SPACE;
                            end else begin
                                r_state   <= S_IDLE;
                                r_ocupado <= 1'b0;
                            end
                        end else if (r_cnt > L_MARK_MAX || r_n == L_MAX_ELEM) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_shift <= '0;
                            r_n     <= '0;
                        end else begin
                            r_shift <= r_shift | (5'(w_dash) << r_n);
                            r_n     <= r_n + 3'd1;
                            r_state <= S_SPACE;
                        end
                    end else if (r_cnt > L_MARK_MAX) begin
                        // Mark too long while still keyed (covers a stuck line).
                        r_state <= S_ERROR;
                        r_error <= 1'b1;
                        r_shift <= '0;
                        r_n     <= '0;
                    end
                end

                S_SPACE: begin
                    if (w_rise) begin
                        r_state <= S_MARK;
                    end else if (w_gap_hit) begin
                        r_codigo   <= r_shift;
                        r_longitud <= r_n;
                        r_valido   <= 1'b1;
                        r_shift    <= '0;
                        r_n        <= '0;
                        r_state    <= S_IDLE;
                        r_ocupado  <= 1'b0;
                    end
                end

                S_ERROR: begin
                    if (w_gap_hit) begin
                        r_state   <= S_IDLE;
                        r_ocupado <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign codigo   = r_codigo;
    assign longitud = r_longitud;
    assign valido   = r_valido;
    assign error    = r_error;
    assign ocupado  = r_ocupado;

endmodule

// File: tb/tb_morse_receptor.sv
// -----------------------------------------------------------------------------
// tb_morse_receptor
//   Drives directed and randomized keying patterns into morse_receptor. Every
//   driven line level and tick is recorded; a run-length reference model then
//   turns the recorded waveform into the expected list of letters and error
//   pulses, which is compared with what the receiver actually reported.
// -----------------------------------------------------------------------------
module tb_morse_receptor;

    localparam int HIST = 8192;
    localparam int LAT  = 2;     // synchroniser delay of linea, in cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       linea;
    logic [4:0] codigo;
    logic [2:0] longitud;
    logic       valido;
    logic       error;
    logic       ocupado;

    morse_receptor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .linea    (linea),
        .codigo   (codigo),
        .longitud (longitud),
        .valido   (valido),
        .error    (error),
        .ocupado  (ocupado)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Recorded stimulus of the current phase, one entry per clock cycle.
    logic lv [HIST];
    logic tk [HIST];
    int   hcnt  = 0;
    int   gstep = 0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    logic [4:0] m_code_last = '0;
    logic [2:0] m_len_last  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed events: {0, codigo, longitud} for a letter, 9'h100 for an error.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valido) obs_q.push_back({1'b0, codigo, longitud});
            if (error)  obs_q.push_back(9'h100);
        end
    end

    task automatic step(input logic lvl);
        @(negedge clk);
        linea = lvl;
        tick  = (gstep % 4 == 1);
        if (hcnt < HIST) begin
            lv[hcnt] = lvl;
            tk[hcnt] = tick;
            hcnt++;
        end
        gstep++;
    endtask

    task automatic hold(input logic lvl, input int nticks);
        repeat (4 * nticks) step(lvl);
    endtask

    task automatic glitch();
        step(1'b1);
        repeat (3) step(1'b0);
    endtask

    task automatic align();
        while (gstep % 4 != 0) step(1'b0);
    endtask

    // Ticks that fall strictly between two line edges (edge cycles seen by
    // the receiver LAT cycles after the drive cycles s and e).
    function automatic int count_ticks(input int s, input int e);
        int k = 0;
        for (int t = s + LAT + 1; t < e + LAT; t++)
            if (t >= 0 && t < hcnt && tk[t]) k++;
        return k;
    endfunction

    // Reference model: walk the recorded line as runs of constant level and
    // apply the dot/dash/gap rules to each run's tick length.
    task automatic run_model();
        int       n      = 0;
        bit [4:0] code   = '0;
        bit       in_err = 1'b0;
        logic     prevl  = 1'b0;
        int       s      = -100;
        int       k;
        for (int c = 0; c <= hcnt; c++) begin
            if (c == hcnt || lv[c] != prevl) begin
                k = count_ticks(s, (c == hcnt) ? hcnt + 16 : c);
                if (prevl) begin
                    if (in_err) begin
                        // marks are ignored until the line has been quiet
                    end else if (k > 6 || (k >= 1 && n == 5)) begin
                        exp_q.push_back(9'h100);
                        in_err = 1'b1;
                        n      = 0;
                        code   = '0;
                    end else if (k >= 1) begin
                        if (k > 2) code[n] = 1'b1;
                        n++;
                    end
                end else begin
                    if (in_err) begin
                        if (k >= 3) in_err = 1'b0;
                    end else if (n > 0 && k >= 3) begin
                        exp_q.push_back({1'b0, code, 3'(n)});
                        m_code_last = code;
                        m_len_last  = 3'(n);
                        n           = 0;
                        code        = '0;
                    end
                end
                s = c;
                if (c < hcnt) prevl = lv[c];
            end
        end
    endtask

    task automatic compare_phase(input string tag);
        int m;
        repeat (8) step(1'b0);
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        run_model();
        check({tag, "_nev"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({tag, "_ev"}, obs_q[i], exp_q[i]);
        check({tag, "_codigo"},   codigo,   m_code_last);
        check({tag, "_longitud"}, longitud, m_len_last);
        check({tag, "_ocupado"},  ocupado,  1'b0);
        obs_q.delete();
        exp_q.delete();
        hcnt = 0;
        align();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        linea = 1'b0;
        tick  = 1'b0;
        #1;
        check("rst_codigo",   codigo,   5'd0);
        check("rst_longitud", longitud, 3'd0);
        check("rst_valido",   valido,   1'b0);
        check("rst_error",    error,    1'b0);
        check("rst_ocupado",  ocupado,  1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        hcnt        = 0;
        m_code_last = '0;
        m_len_last  = '0;
        align();
    endtask

    initial begin
        rst_n = 1'b0;
        linea = 1'b0;
        tick  = 1'b0;
        do_reset();

        // "A": dot, dash
        hold(1, 1); hold(0, 1); hold(1, 3); hold(0, 6);
        compare_phase("A");
        check("A_code", codigo, 5'b00010);
        check("A_len",  longitud, 3'd2);

        // Five dashes
        for (int i = 0; i < 5; i++) begin
            hold(1, 3);
            hold(0, (i == 4) ? 6 : 1);
        end
        compare_phase("dash5");
        check("dash5_code", codigo, 5'b11111);
        check("dash5_len",  longitud, 3'd5);

        // Six dots overflow: error, old code kept
        for (int i = 0; i < 6; i++) begin
            hold(1, 1);
            hold(0, (i == 5) ? 6 : 1);
        end
        compare_phase("over6");
        check("over6_code_kept", codigo, 5'b11111);

        // Stuck-high line
        hold(1, 10);
        check("stuck_busy", ocupado, 1'b1);
        hold(0, 6);
        compare_phase("stuck");

        // Glitch between dot and dash
        hold(1, 1); hold(0, 1); glitch(); hold(1, 3); hold(0, 6);
        compare_phase("glitch");
        check("glitch_code", codigo, 5'b00010);
        check("glitch_len",  longitud, 3'd2);

        // Reset during the second element, then a clean "A"
        hold(1, 1); hold(0, 1);
        repeat (6) step(1'b1);
        check("midsym_busy", ocupado, 1'b1);
        do_reset();
        hold(1, 1); hold(0, 1); hold(1, 3); hold(0, 6);
        compare_phase("postrst");
        check("postrst_code", codigo, 5'b00010);

        // Randomized letters, occasional overflow, long marks and glitches
        for (int l = 0; l < 40; l++) begin
            int ne;
            ne = ($urandom % 8 == 0) ? 6 : 1 + int'($urandom % 5);
            for (int e = 0; e < ne; e++) begin
                int dur;
                if ($urandom % 12 == 0)   dur = 7 + int'($urandom % 3);
                else if ($urandom % 2)    dur = 1 + int'($urandom % 2);
                else                      dur = 3 + int'($urandom % 4);
                hold(1, dur);
                if (e != ne - 1) begin
                    if ($urandom % 6 == 0) begin
                        hold(0, 1);
                        glitch();
                        hold(0, int'($urandom % 2));
                    end else begin
                        hold(0, 1 + int'($urandom % 2));
                    end
                end
            end
            hold(0, 3 + int'($urandom % 3));
            compare_phase("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
